lsu_dmem_master: RTL and testbench
==================================

# lsu_dmem_master

Load/store initiator for the MEM stage of the five-stage RISC-V pipeline. It accepts one load or store per handshake from the pipeline and drives the data-memory port: address, read_write, data_in and access_size out, with data_out sampled back. It aligns addresses, extracts and sign- or zero-extends sub-word load data, merges sub-word store data, and flags misaligned, illegal or out-of-range accesses. It sits between the MEM-stage control and the data memory.

## Interface
- `DMEM_BASE`, default `32'h01000000`: lowest legal data byte address.
- `DMEM_SIZE`, default `32'h00100000`: size of the legal window in bytes.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V funct3. Loads: LB, LH, LW, LBU, LHU. Stores: SB, SH, SW.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and faults.
- `resp_fault` out 1: access rejected; valid with `resp_valid`.
- `mem_address` out 32: memory byte address.
- `mem_read_write` out 1: 1 = write.
- `mem_data_in` out 32: write data.
- `mem_access_size` out 2: 0 = byte, 1 = half, 2 = word.
- `mem_data_out` in 32: combinational read data.

## Operation
- The FSM has five states: IDLE, READ, WRITE, RESP and FAULT.
- `req_ready` is 1 only when the state is IDLE and `reset` is low.
- Accept: `req_valid & req_ready`. On accept, all request fields are registered.
- Fault check at accept. A fault is raised for any of:
  - half access with `addr[0]`=1;
  - word access with `addr[1:0]`≠0;
  - illegal funct3 (load 011/110/111; store ≥011);
  - `addr < DMEM_BASE`;
  - `addr > DMEM_BASE+DMEM_SIZE-4`.
- On a fault the FSM goes to FAULT. No memory access occurs, and `mem_read_write` stays 0.
- Otherwise the next state is:
  - load: READ;
  - SW: WRITE;
  - SB/SH: READ (read-modify-write, see Configuration).
- READ:
  - Drives `mem_address = {addr[31:2],2'b00}`, `mem_access_size=2`, `mem_read_write=0`.
  - Captures `mem_data_out` into a word register at the clock edge.
- Load extract:
  - Shift the captured word right by `8*addr[1:0]`.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.
- Store merge (SB/SH):
  - Replace byte lane `addr[1:0]`, or half lane `addr[1]`, of the read word with `req_wdata[7:0]` or `[15:0]`.
  - SW uses `req_wdata` unchanged.
- WRITE:
  - Drives the aligned address, `mem_access_size=2`, `mem_read_write=1` and the merged data.
  - Lasts exactly one cycle.
- RESP: `resp_valid=1`, `resp_fault=0`; `resp_rdata` = extracted load data, or 0 for stores. Next state is IDLE.
- FAULT: `resp_valid=1`, `resp_fault=1`, `resp_rdata=0`. Next state is IDLE.
- All `mem_*` and `resp_*` outputs are registered from state, so `mem_read_write` is glitch-free.
- Outside READ and WRITE, `mem_read_write`=0 and `mem_data_in`=0. `mem_address` holds its last value.

## Timing
- Reset values:
  - state IDLE;
  - `req_ready` 0 during reset, 1 in the first cycle after;
  - `resp_valid` 0, `resp_rdata` 0, `resp_fault` 0;
  - `mem_address` 0, `mem_read_write` 0, `mem_data_in` 0, `mem_access_size` 2.
- Latency from the accept edge to the `resp_valid` cycle:
  - load: 2 cycles;
  - SW: 2 cycles;
  - SB/SH with RMW: 3 cycles;
  - fault: 1 cycle.
- The next accept is possible in the cycle after RESP or FAULT, giving a throughput of 1 request per 3–4 cycles.
- `req_valid` may stay high. Requests presented while `req_ready`=0 are ignored, not queued.
- The response pulse has no backpressure; the consumer must take it in that cycle.
- Reset mid-operation:
  - The transaction is aborted and no `resp_valid` is issued.
  - A write already being driven in the cycle `reset` is sampled completes.
  - No later write occurs.
- `addr = DMEM_BASE+DMEM_SIZE-4` is legal for a word access.

## Configuration
- `LSU_RMW_EN` defined:
  - SB/SH use READ→WRITE read-modify-write with word-wide memory accesses.
  - The memory always sees `mem_access_size=2`.
- `LSU_RMW_EN` undefined:
  - SB/SH go straight to WRITE with `mem_address=req_addr` (unaligned), `mem_access_size` 0 or 1, and `mem_data_in = req_wdata` masked to 8 or 16 bits.
  - Latency is 2 cycles; the memory is responsible for sub-word writes.
  - Loads and SW are unchanged.

## Test plan
- LW at `0x01000010`, memory word `0xDEADBEEF` → `resp_valid` 2 cycles after accept, `resp_rdata=0xDEADBEEF`, `mem_read_write` never 1.
- LB vs LBU from the same word:
  - LB at `0x01000013`, word `0x80FF7F01` → `0xFFFFFF80`;
  - LBU at the same address → `0x00000080`;
  - LH at `0x01000012` → `0xFFFF80FF`.
- SB with `LSU_RMW_EN`: word `0x11223344`, SB `0xAA` at `0x01000021` → one READ, then one WRITE of `0x1122AA44` to `0x01000020`; response 3 cycles after accept.
- Faults:
  - LW at `0x01000002` → `resp_fault=1` after 1 cycle, no memory write;
  - SW at `0x00FFFFFC` → fault;
  - funct3 `3'b011` load → fault.
- Reset asserted during the READ of an SH → no `resp_valid`, no write, `req_ready=1` in the cycle after reset deasserts.
- Back-to-back: `req_valid` held high for SW then LW to the same address → the LW returns the stored value; `req_ready` is low during busy states.

Source files
------------

// File: rtl/lsu_dmem_master.sv
// rtl/lsu_dmem_master.sv - MEM-stage load/store initiator driving the data-memory port
// Optional build macro LSU_RMW_EN: sub-word stores done as word read-modify-write.
module lsu_dmem_master #(
    parameter logic [31:0] DMEM_BASE = 32'h01000000,
    parameter logic [31:0] DMEM_SIZE = 32'h00100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_address,
    output logic        mem_read_write,
    output logic [31:0] mem_data_in,
    output logic [1:0]  mem_access_size,
    input  logic [31:0] mem_data_out
);

    localparam logic [31:0] DMEM_LIMIT = DMEM_BASE + DMEM_SIZE - 32'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RESP,
        S_FAULT
    } state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_fault_q, resp_fault_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic        mem_read_write_q, mem_read_write_d;
    logic [31:0] mem_data_in_q, mem_data_in_d;
    logic [1:0]  mem_access_size_q, mem_access_size_d;

    logic accept;
    logic misaligned;
    logic illegal_op;
    logic out_of_range;
    logic req_fault;

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  f3);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b010:  return sh;
            3'b100:  return {24'd0, sh[7:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3,
                                                input logic [31:0] wdata);
        logic [4:0]  sh;
        logic [31:0] mask;
        logic [31:0] data;
        case (f3[1:0])
            2'b00: begin
                sh   = {off, 3'b000};
                mask = 32'h000000FF << sh;
                data = {24'd0, wdata[7:0]} << sh;
                return (word & ~mask) | data;
            end
            2'b01: begin
                sh   = {off[1], 4'b0000};
                mask = 32'h0000FFFF << sh;
                data = {16'd0, wdata[15:0]} << sh;
                return (word & ~mask) | data;
            end
            default: return wdata;
        endcase
    endfunction

    assign req_ready = (state_q == S_IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    assign misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign illegal_op   = req_write ? (req_funct3 >= 3'b011)
                                    : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
    assign out_of_range = (req_addr < DMEM_BASE) || (req_addr > DMEM_LIMIT);
    assign req_fault    = misaligned || illegal_op || out_of_range;

    always_comb begin
        state_d           = state_q;
        write_d           = write_q;
        funct3_d          = funct3_q;
        addr_d            = addr_q;
        wdata_d           = wdata_q;
        resp_valid_d      = 1'b0;
        resp_rdata_d      = 32'd0;
        resp_fault_d      = 1'b0;
        mem_address_d     = mem_address_q;
        mem_read_write_d  = 1'b0;
        mem_data_in_d     = 32'd0;
        mem_access_size_d = mem_access_size_q;

        // Outputs are computed from the next state so they appear registered in that state.
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    write_d  = req_write;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (req_fault) begin
                        state_d      = S_FAULT;
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                    end else if (!req_write) begin
                        state_d           = S_READ;
                        mem_address_d     = {req_addr[31:2], 2'b00};
                        mem_access_size_d = 2'd2;
                    end else if (req_funct3[1:0] == 2'b10) begin
                        state_d           = S_WRITE;
                        mem_address_d     = {req_addr[31:2], 2'b00};
                        mem_access_size_d = 2'd2;
                        mem_read_write_d  = 1'b1;
                        mem_data_in_d     = req_wdata;
                    end else begin
`ifdef LSU_RMW_EN
                        state_d           = S_READ;
                        mem_address_d     = {req_addr[31:2], 2'b00};
                        mem_access_size_d = 2'd2;
`else
                        state_d           = S_WRITE;
                        mem_address_d     = req_addr;
                        mem_access_size_d = req_funct3[1:0];
                        mem_read_write_d  = 1'b1;
                        mem_data_in_d     = req_funct3[0] ? {16'd0, req_wdata[15:0]}
                                                          : {24'd0, req_wdata[7:0]};
`endif
                    end
                end
            end
            S_READ: begin
                if (write_q) begin
                    state_d           = S_WRITE;
                    mem_address_d     = {addr_q[31:2], 2'b00};
                    mem_access_size_d = 2'd2;
                    mem_read_write_d  = 1'b1;
                    mem_data_in_d     = store_merge(mem_data_out, addr_q[1:0], funct3_q, wdata_q);
                end else begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_extract(mem_data_out, addr_q[1:0], funct3_q);
                end
            end
            S_WRITE: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
            end
            S_RESP:  state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q           <= S_IDLE;
            write_q           <= 1'b0;
            funct3_q          <= 3'd0;
            addr_q            <= 32'd0;
            wdata_q           <= 32'd0;
            resp_valid_q      <= 1'b0;
            resp_rdata_q      <= 32'd0;
            resp_fault_q      <= 1'b0;
            mem_address_q     <= 32'd0;
            mem_read_write_q  <= 1'b0;
            mem_data_in_q     <= 32'd0;
            mem_access_size_q <= 2'd2;
        end else begin
            state_q           <= state_d;
            write_q           <= write_d;
            funct3_q          <= funct3_d;
            addr_q            <= addr_d;
            wdata_q           <= wdata_d;
            resp_valid_q      <= resp_valid_d;
            resp_rdata_q      <= resp_rdata_d;
            resp_fault_q      <= resp_fault_d;
            mem_address_q     <= mem_address_d;
            mem_read_write_q  <= mem_read_write_d;
            mem_data_in_q     <= mem_data_in_d;
            mem_access_size_q <= mem_access_size_d;
        end
    end

    assign resp_valid      = resp_valid_q;
    assign resp_rdata      = resp_rdata_q;
    assign resp_fault      = resp_fault_q;
    assign mem_address     = mem_address_q;
    assign mem_read_write  = mem_read_write_q;
    assign mem_data_in     = mem_data_in_q;
    assign mem_access_size = mem_access_size_q;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// tb/tb_lsu_dmem_master.sv - self-checking bench for lsu_dmem_master
module tb_lsu_dmem_master;

    localparam logic [31:0] BASE = 32'h01000000;
    localparam logic [31:0] SIZE = 32'h00100000;
`ifdef LSU_RMW_EN
    localparam int          SUB_LAT    = 3;
    localparam logic [31:0] SB_WR_ADDR = 32'h01000020;
    localparam logic [31:0] SB_WR_DATA = 32'h1122AA44;
    localparam logic [31:0] SB_WR_SIZE = 32'd2;
    localparam logic [31:0] RST_WRITES = 32'd0;
`else
    localparam int          SUB_LAT    = 2;
    localparam logic [31:0] SB_WR_ADDR = 32'h01000021;
    localparam logic [31:0] SB_WR_DATA = 32'h000000AA;
    localparam logic [31:0] SB_WR_SIZE = 32'd0;
    localparam logic [31:0] RST_WRITES = 32'd1;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic        mem_read_write;
    logic [31:0] mem_data_in;
    logic [1:0]  mem_access_size;
    logic [31:0] mem_data_out;

    lsu_dmem_master dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_address(mem_address), .mem_read_write(mem_read_write),
        .mem_data_in(mem_data_in), .mem_access_size(mem_access_size),
        .mem_data_out(mem_data_out)
    );

    always #5 clock = ~clock;

    // Environment memory: 16 words, aliased on address bits [5:2].
    logic [31:0] env_mem [16];
    logic [31:0] ref_mem [16];
    int          wr_count = 0;
    logic [31:0] last_wr_addr = 32'd0;
    logic [31:0] last_wr_data = 32'd0;
    logic [1:0]  last_wr_size = 2'd0;

    assign mem_data_out = env_mem[mem_address[5:2]];

    always @(posedge clock) begin
        if (mem_read_write) begin
            wr_count     <= wr_count + 1;
            last_wr_addr <= mem_address;
            last_wr_data <= mem_data_in;
            last_wr_size <= mem_access_size;
            case (mem_access_size)
                2'd0:    env_mem[mem_address[5:2]][{mem_address[1:0], 3'b000} +: 8] <= mem_data_in[7:0];
                2'd1:    env_mem[mem_address[5:2]][{mem_address[1], 4'b0000} +: 16] <= mem_data_in[15:0];
                default: env_mem[mem_address[5:2]] <= mem_data_in;
            endcase
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic flt, output logic [31:0] rd,
                          output int lat, output int nwr);
        int w0;
        @(posedge clock); #2;
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
        w0 = wr_count;
        @(posedge clock); #2;
        req_valid = 1'b0;
        lat = 0; flt = 1'b0; rd = 32'd0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clock);
            if (resp_valid) begin
                lat = n; flt = resp_fault; rd = resp_rdata;
                break;
            end
        end
        nwr = wr_count - w0;
    endtask

    // Reference model: byte-level view of memory, rules applied directly.
    function automatic void ref_run(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] wd, output logic flt,
                                    output logic [31:0] rd, output int lat);
        int         sz;
        int         off;
        logic       legal;
        logic [7:0] b [4];
        logic [31:0] w;
        case (f3[1:0])
            2'd0: sz = 1;
            2'd1: sz = 2;
            2'd2: sz = 4;
            default: sz = 1;
        endcase
        legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        flt = !legal || ((a % 32'(sz)) != 0) || (a < BASE) || (a > BASE + SIZE - 32'd4);
        rd = 32'd0;
        lat = 1;
        if (!flt) begin
            w = ref_mem[a[5:2]];
            off = int'(a[1:0]);
            for (int k = 0; k < 4; k++) b[k] = w[8*k +: 8];
            if (!wr) begin
                for (int k = 0; k < sz; k++) rd = rd | (32'(b[off+k]) << (8*k));
                if (!f3[2] && sz < 4 && rd[8*sz-1]) rd = rd | (32'hFFFFFFFF << (8*sz));
                lat = 2;
            end else begin
                for (int k = 0; k < sz; k++) b[off+k] = wd[8*k +: 8];
                ref_mem[a[5:2]] = {b[3], b[2], b[1], b[0]};
                lat = (sz == 4) ? 2 : SUB_LAT;
            end
        end
    endfunction

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pre;
        logic        flt;
        logic [31:0] rdata;
        int          lat;
        logic [31:0] post;
    } vec_t;

    vec_t        tbl [17];
    logic        g_flt, e_flt, r_wr;
    logic [31:0] g_rd, e_rd, r_a, r_wd, v;
    logic [2:0]  r_f3;
    int          g_lat, e_lat, g_nwr, w0, seen, rdy, nresp, sel;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{1'b0, 3'b010, 32'h01000010, 32'h0,        32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 2,       32'hDEADBEEF};
        tbl[1]  = '{1'b0, 3'b000, 32'h01000013, 32'h0,        32'h80FF7F01, 1'b0, 32'hFFFFFF80, 2,       32'h80FF7F01};
        tbl[2]  = '{1'b0, 3'b100, 32'h01000013, 32'h0,        32'h80FF7F01, 1'b0, 32'h00000080, 2,       32'h80FF7F01};
        tbl[3]  = '{1'b0, 3'b001, 32'h01000012, 32'h0,        32'h80FF7F01, 1'b0, 32'hFFFF80FF, 2,       32'h80FF7F01};
        tbl[4]  = '{1'b0, 3'b101, 32'h01000012, 32'h0,        32'h80FF7F01, 1'b0, 32'h000080FF, 2,       32'h80FF7F01};
        tbl[5]  = '{1'b0, 3'b010, 32'h01000002, 32'h0,        32'h12345678, 1'b1, 32'h0,        1,       32'h12345678};
        tbl[6]  = '{1'b1, 3'b010, 32'h00FFFFFC, 32'hCAFEF00D, 32'h0BADF00D, 1'b1, 32'h0,        1,       32'h0BADF00D};
        tbl[7]  = '{1'b0, 3'b011, 32'h01000010, 32'h0,        32'h55555555, 1'b1, 32'h0,        1,       32'h55555555};
        tbl[8]  = '{1'b0, 3'b010, 32'h010FFFFC, 32'h0,        32'h5A5AA5A5, 1'b0, 32'h5A5AA5A5, 2,       32'h5A5AA5A5};
        tbl[9]  = '{1'b0, 3'b010, 32'h01100000, 32'h0,        32'h77777777, 1'b1, 32'h0,        1,       32'h77777777};
        tbl[10] = '{1'b1, 3'b001, 32'h01000023, 32'h1234,     32'h66666666, 1'b1, 32'h0,        1,       32'h66666666};
        tbl[11] = '{1'b1, 3'b011, 32'h01000010, 32'hFFFFFFFF, 32'h44444444, 1'b1, 32'h0,        1,       32'h44444444};
        tbl[12] = '{1'b1, 3'b000, 32'h01000021, 32'h000000AA, 32'h11223344, 1'b0, 32'h0,        SUB_LAT, 32'h1122AA44};
        tbl[13] = '{1'b1, 3'b001, 32'h01000022, 32'h1234BEEF, 32'h11223344, 1'b0, 32'h0,        SUB_LAT, 32'hBEEF3344};
        tbl[14] = '{1'b1, 3'b010, 32'h01000030, 32'hCAFEF00D, 32'h00000000, 1'b0, 32'h0,        2,       32'hCAFEF00D};
        tbl[15] = '{1'b0, 3'b000, 32'h00FFFFFF, 32'h0,        32'h33333333, 1'b1, 32'h0,        1,       32'h33333333};
        tbl[16] = '{1'b0, 3'b110, 32'h01000010, 32'h0,        32'h22222222, 1'b1, 32'h0,        1,       32'h22222222};

        for (int i = 0; i < 16; i++) env_mem[i] <= 32'd0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_rw", {31'd0, mem_read_write}, 32'd0);
        chk("rst_mem_data_in", mem_data_in, 32'd0);
        chk("rst_mem_size", {30'd0, mem_access_size}, 32'd2);
        @(posedge clock); #2;
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 17; i++) begin
            env_mem[tbl[i].addr[5:2]] <= tbl[i].pre;
            do_req(tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wdata, g_flt, g_rd, g_lat, g_nwr);
            chk($sformatf("vec%0d_fault", i), {31'd0, g_flt}, {31'd0, tbl[i].flt});
            chk($sformatf("vec%0d_rdata", i), g_rd, tbl[i].rdata);
            chk($sformatf("vec%0d_latency", i), 32'(g_lat), 32'(tbl[i].lat));
            chk($sformatf("vec%0d_writes", i), 32'(g_nwr), (tbl[i].wr && !tbl[i].flt) ? 32'd1 : 32'd0);
            chk($sformatf("vec%0d_memword", i), env_mem[tbl[i].addr[5:2]], tbl[i].post);
        end

        env_mem[8] <= 32'h11223344;
        do_req(1'b1, 3'b000, 32'h01000021, 32'h000000AA, g_flt, g_rd, g_lat, g_nwr);
        chk("sb_latency", 32'(g_lat), 32'(SUB_LAT));
        chk("sb_writes", 32'(g_nwr), 32'd1);
        chk("sb_wr_addr", last_wr_addr, SB_WR_ADDR);
        chk("sb_wr_data", last_wr_data, SB_WR_DATA);
        chk("sb_wr_size", {30'd0, last_wr_size}, SB_WR_SIZE);

        @(posedge clock); #2;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h01000022; req_wdata = 32'h0000BEEF;
        w0 = wr_count;
        @(posedge clock); #2;
        req_valid = 1'b0; reset = 1'b1;
        @(posedge clock); #2;
        reset = 1'b0;
        @(negedge clock);
        chk("rstmid_ready", {31'd0, req_ready}, 32'd1);
        chk("rstmid_mem_rw", {31'd0, mem_read_write}, 32'd0);
        seen = resp_valid ? 1 : 0;
        repeat (4) begin
            @(negedge clock);
            if (resp_valid) seen++;
        end
        chk("rstmid_no_resp", 32'(seen), 32'd0);
        chk("rstmid_writes", 32'(wr_count - w0), RST_WRITES);

        @(posedge clock); #2;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h01000034; req_wdata = 32'h89ABCDEF;
        @(posedge clock); #2;
        req_write = 1'b0; req_wdata = 32'd0;
        rdy = 0; nresp = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clock);
            if (req_ready) rdy++;
            if (resp_valid) begin
                nresp++;
                if (nresp == 1) begin
                    chk("b2b_sw_rdata", resp_rdata, 32'd0);
                    chk("b2b_sw_fault", {31'd0, resp_fault}, 32'd0);
                end else begin
                    chk("b2b_lw_rdata", resp_rdata, 32'h89ABCDEF);
                    req_valid = 1'b0;
                    break;
                end
            end
        end
        req_valid = 1'b0;
        chk("b2b_responses", 32'(nresp), 32'd2);
        chk("b2b_ready_cycles", 32'(rdy), 32'd1);

        for (int i = 0; i < 16; i++) begin
            v = $urandom;
            env_mem[i] <= v;
            ref_mem[i] = v;
        end
        for (int it = 0; it < 300; it++) begin
            r_wr = 1'($urandom_range(0, 1));
            r_f3 = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            if (sel < 7)      r_a = BASE + 32'($urandom_range(0, 63));
            else if (sel < 9) r_a = BASE + SIZE - 32'd64 + 32'($urandom_range(0, 63));
            else              r_a = BASE - 32'd1 - 32'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) r_a[1:0] = 2'b00;
            r_wd = $urandom;
            ref_run(r_wr, r_f3, r_a, r_wd, e_flt, e_rd, e_lat);
            do_req(r_wr, r_f3, r_a, r_wd, g_flt, g_rd, g_lat, g_nwr);
            chk($sformatf("rnd%0d_fault", it), {31'd0, g_flt}, {31'd0, e_flt});
            chk($sformatf("rnd%0d_rdata", it), g_rd, e_rd);
            chk($sformatf("rnd%0d_latency", it), 32'(g_lat), 32'(e_lat));
            chk($sformatf("rnd%0d_writes", it), 32'(g_nwr), (r_wr && !e_flt) ? 32'd1 : 32'd0);
            chk($sformatf("rnd%0d_memword", it), env_mem[r_a[5:2]], ref_mem[r_a[5:2]]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
